multimode_counter: RTL and testbench
====================================

MULTIMODE_COUNTER -- requirements
Module: multimode_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter SATURATE, default 0, where 0 selects wrap at terminal and 1 selects hold at terminal.
REQ-003 Port clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 Port en  input  1  SHALL be the count enable; when low, mode operations hold.
REQ-006 Port set  input  1  SHALL force the count to all ones.
REQ-007 Port load  input  1  SHALL load load_val into the count.
REQ-008 Port load_val  input  WIDTH  SHALL be the parallel load value.
REQ-009 Port mode  input  2  SHALL select the operation: 00 up, 01 down, 10 rotate-left, 11 rotate-right.
REQ-010 Port limit  input  WIDTH  SHALL be the terminal value for up counting and the wrap target for down counting.
REQ-011 Port count  output  WIDTH  SHALL be the registered counter value.
REQ-012 Port tc  output  1  SHALL be the registered terminal-count flag.
REQ-013 Port zero  output  1  SHALL be high exactly when count == 0 (combinational from count).

Function
REQ-014 Per-edge priority SHALL be set > load > en; set or load SHALL act regardless of en and mode.
REQ-015 set SHALL write all ones to count, ignoring limit, and clear tc.
REQ-016 load SHALL write load_val to count next edge (1-cycle latency) and clear tc.
REQ-017 en low with no set/load SHALL hold count and clear tc.
REQ-018 Up (mode 00), en high: count < limit gives count+1 and tc=0.
REQ-019 Up, count >= limit (includes values above limit after load/set): SATURATE=0 gives count=0; SATURATE=1 gives count=limit; tc=1 in both cases.
REQ-020 Down (mode 01), en high: count != 0 gives count-1 and tc=0.
REQ-021 Down, count == 0: SATURATE=0 gives count=limit; SATURATE=1 holds count at 0; tc=1.
REQ-022 Rotate-left (mode 10) SHALL give {count[WIDTH-2:0], count[WIDTH-1]}; rotate-right (mode 11) SHALL give {count[0], count[WIDTH-1:1]}; tc=0 in both, and limit SHALL be ignored.
REQ-023 tc SHALL be high for each edge on which a terminal step (REQ-019/021) occurred; in saturate mode it stays high every enabled cycle while the count is held at the terminal value.
REQ-024 limit == 0 in up mode SHALL keep count at 0 with tc=1 every enabled cycle.
REQ-025 mode and limit changes SHALL take effect on the next edge with no pipeline delay; intermediate arithmetic SHALL be WIDTH bits, with no carry out.
REQ-026 Mode changes mid-count SHALL operate on the current count value with no flush cycle.

Reset
REQ-027 reset high SHALL immediately force count=0 and tc=0 (so zero=1), independent of clk.
REQ-028 reset SHALL override set, load and en; after reset deasserts, operation resumes on the first rising edge with all inputs sampled normally.
REQ-029 reset asserted mid-count or mid-rotate SHALL discard state entirely, leaving no residual tc pulse.

Verification (WIDTH=8)
REQ-030 Up wrap: SATURATE=0, limit=5, en=1, mode=00 from reset -> count 1,2,3,4,5,0; tc=1 only on the edge producing 0.
REQ-031 Down saturate: SATURATE=1, load_val=2 with load, then mode=01, en=1 -> count 2,1,0,0,0; tc=1 on each edge holding 0; zero=1 from third value.
REQ-032 Rotate: load 8'b1000_0001, mode=10 for two edges -> 0000_0011, 0000_0110; then mode=11 -> 0000_0011; tc=0 throughout.
REQ-033 Priority: set=1, load=1, load_val=8'h3C, en=1 on the same edge -> count=8'hFF, tc=0; next edge, up mode, limit=8'h10, SATURATE=0 -> count=0, tc=1.
REQ-034 Async reset: count=8'h2A counting up; assert reset between edges -> count=0, tc=0, zero=1 before the next rising edge; deassert -> next edge count=1.
REQ-035 Limit zero / enable hold: limit=0, mode=00, en=1 -> count stays 0, tc=1 each edge; en=0 -> count holds, tc=0.

Source files
------------

// File: rtl/multimode_counter.sv
// Multimode counter: up/down with wrap or saturate at a programmable limit,
// plus rotate-left/right, with set/load overrides and a registered terminal flag.
module multimode_counter #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             set,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             zero
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_ROL  = 2'b10,
    MODE_ROR  = 2'b11
  } mode_e;

  localparam bit SAT = (SATURATE != 0);

  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  mode_e            op;

  assign op = mode_e'(mode);

  // tc defaults low so it only pulses on edges that actually take a terminal step.
  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    if (set) begin
      count_nxt = '1;
    end else if (load) begin
      count_nxt = load_val;
    end else if (en) begin
      case (op)
        MODE_UP: begin
          if (count < limit) begin
            count_nxt = count + 1'b1;
          end else begin
            count_nxt = SAT ? limit : '0;
            tc_nxt    = 1'b1;
          end
        end
        MODE_DOWN: begin
          if (count != '0) begin
            count_nxt = count - 1'b1;
          end else begin
            count_nxt = SAT ? '0 : limit;
            tc_nxt    = 1'b1;
          end
        end
        MODE_ROL: count_nxt = {count[WIDTH-2:0], count[WIDTH-1]};
        MODE_ROR: count_nxt = {count[0], count[WIDTH-1:1]};
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
    end
  end

  assign zero = (count == '0);

endmodule

// File: tb/tb_multimode_counter.sv
// Directed bench: wrap (SATURATE=0) and saturate (SATURATE=1) instances share stimulus
// and are checked against hand-computed values.
module tb_multimode_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, set, load;
  logic [7:0] load_val, limit;
  logic [1:0] mode;
  logic [7:0] count0, count1;
  logic       tc0, tc1, zero0, zero1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multimode_counter #(.WIDTH(8), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .set(set), .load(load),
    .load_val(load_val), .mode(mode), .limit(limit),
    .count(count0), .tc(tc0), .zero(zero0)
  );

  multimode_counter #(.WIDTH(8), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .set(set), .load(load),
    .load_val(load_val), .mode(mode), .limit(limit),
    .count(count1), .tc(tc1), .zero(zero1)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check both instances in one call: expected count/tc for wrap then saturate.
  task automatic chk2(input string tag, input logic [7:0] c0, input logic t0,
                      input logic [7:0] c1, input logic t1);
    chk({tag, " wrap count"}, count0, c0);
    chk({tag, " wrap tc"},    tc0,    t0);
    chk({tag, " wrap zero"},  zero0,  c0 == 8'h00);
    chk({tag, " sat count"},  count1, c1);
    chk({tag, " sat tc"},     tc1,    t1);
    chk({tag, " sat zero"},   zero1,  c1 == 8'h00);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; set = 1'b0; load = 1'b0;
    load_val = 8'h00; limit = 8'h00; mode = 2'b00;
    #1;
    chk2("reset", 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    step();
    reset = 1'b0;

    // Up count to limit 5: wrap goes to 0, saturate holds at 5.
    limit = 8'd5; en = 1'b1; mode = 2'b00;
    for (int i = 0; i < 6; i++) begin
      step();
      chk2($sformatf("up%0d", i),
           (i < 5) ? 8'(i + 1) : 8'd0, i == 5,
           (i < 5) ? 8'(i + 1) : 8'd5, i == 5);
    end

    // Load 2 then count down.
    load = 1'b1; load_val = 8'd2; mode = 2'b01;
    step();
    chk2("dn load", 8'd2, 1'b0, 8'd2, 1'b0);
    load = 1'b0;
    step(); chk2("dn0", 8'd1, 1'b0, 8'd1, 1'b0);
    step(); chk2("dn1", 8'd0, 1'b0, 8'd0, 1'b0);
    step(); chk2("dn2", 8'd5, 1'b1, 8'd0, 1'b1);
    step(); chk2("dn3", 8'd4, 1'b0, 8'd0, 1'b1);

    // Rotate left twice then right once.
    load = 1'b1; load_val = 8'h81; mode = 2'b10;
    step(); chk2("rot load", 8'h81, 1'b0, 8'h81, 1'b0);
    load = 1'b0;
    step(); chk2("rol0", 8'h03, 1'b0, 8'h03, 1'b0);
    step(); chk2("rol1", 8'h06, 1'b0, 8'h06, 1'b0);
    mode = 2'b11;
    step(); chk2("ror0", 8'h03, 1'b0, 8'h03, 1'b0);

    // set beats load; all-ones above limit takes a terminal step next.
    set = 1'b1; load = 1'b1; load_val = 8'h3C; en = 1'b1;
    step(); chk2("prio", 8'hFF, 1'b0, 8'hFF, 1'b0);
    set = 1'b0; load = 1'b0; mode = 2'b00; limit = 8'h10;
    step(); chk2("above lim", 8'h00, 1'b1, 8'h10, 1'b1);

    // Async reset between edges while counting up from 0x2A.
    load = 1'b1; load_val = 8'h2A; limit = 8'hFF;
    step(); chk2("ld 2a", 8'h2A, 1'b0, 8'h2A, 1'b0);
    load = 1'b0;
    step(); chk2("cnt 2b", 8'h2B, 1'b0, 8'h2B, 1'b0);
    #2 reset = 1'b1;
    #1 chk2("async rst", 8'h00, 1'b0, 8'h00, 1'b0);
    set = 1'b1;
    step(); chk2("rst over set", 8'h00, 1'b0, 8'h00, 1'b0);
    set = 1'b0; reset = 1'b0;
    step(); chk2("post rst", 8'h01, 1'b0, 8'h01, 1'b0);

    // limit 0 in up mode pins count at 0 with tc every enabled edge.
    limit = 8'h00;
    step(); chk2("lim0 a", 8'h00, 1'b1, 8'h00, 1'b1);
    step(); chk2("lim0 b", 8'h00, 1'b1, 8'h00, 1'b1);
    en = 1'b0;
    step(); chk2("en hold 0", 8'h00, 1'b0, 8'h00, 1'b0);
    load = 1'b1; load_val = 8'h07;
    step(); chk2("ld no en", 8'h07, 1'b0, 8'h07, 1'b0);
    load = 1'b0; mode = 2'b01;
    step(); chk2("en hold 7", 8'h07, 1'b0, 8'h07, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
